// File: rtl/state_frame_rx_if.sv
// rtl/state_frame_rx_if.sv - received-byte stream from the UART byte receiver
interface state_frame_rx_if;
    logic       arrived;
    logic [7:0] data;

    modport master (output arrived, output data);
    modport slave  (input  arrived, input  data);
endinterface

// File: rtl/state_frame_rx.sv
// rtl/state_frame_rx.sv - 0x5A-framed state-report parser with XOR checksum and inter-byte timeout
module state_frame_rx #(
    parameter int         PAYLOAD_BYTES  = 6,
    parameter logic [7:0] HEADER         = 8'h5A,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                         Clock,
    input  logic                         Reset,
    state_frame_rx_if.slave              rx,
    output logic [8*PAYLOAD_BYTES-1:0]   payload,
    output logic                         frame_valid,
    output logic                         cksum_err,
    output logic                         timeout_err,
    output logic                         busy,
    output logic [7:0]                   err_count
);
    localparam int PW = 8 * PAYLOAD_BYTES;
    localparam int CW = $clog2(PAYLOAD_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   buf_q, buf_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      xor_q, xor_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            pend_ok_q, pend_ok_d;
    logic            pend_bad_q, pend_bad_d;
    logic [PW-1:0]   payload_q, payload_d;
    logic            frame_valid_q, frame_valid_d;
    logic            cksum_err_q, cksum_err_d;
    logic            timeout_err_q, timeout_err_d;
    logic            busy_q, busy_d;
    logic [7:0]      err_count_q, err_count_d;
    logic            tmo_expired;

    assign tmo_expired = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d       = state_q;
        buf_d         = buf_q;
        cnt_d         = cnt_q;
        xor_d         = xor_q;
        tmo_d         = tmo_q;
        pend_ok_d     = 1'b0;
        pend_bad_d    = 1'b0;
        timeout_err_d = 1'b0;
        // The checksum verdict is held one cycle so the strobe and payload
        // update land on the edge after the checksum byte was sampled.
        frame_valid_d = pend_ok_q;
        cksum_err_d   = pend_bad_q;
        payload_d     = pend_ok_q ? buf_q : payload_q;

        case (state_q)
            HUNT: begin
                if (rx.arrived && rx.data == HEADER) begin
                    xor_d   = HEADER;
                    cnt_d   = '0;
                    tmo_d   = '0;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (rx.arrived) begin
                    buf_d = {buf_q[PW-9:0], rx.data};
                    xor_d = xor_q ^ rx.data;
                    cnt_d = cnt_q + 1'b1;
                    tmo_d = '0;
                    if (cnt_q == CW'(PAYLOAD_BYTES - 1)) begin
                        state_d = CHECK;
                    end
                end else if (tmo_expired) begin
                    timeout_err_d = 1'b1;
                    tmo_d         = '0;
                    state_d       = HUNT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            CHECK: begin
                if (rx.arrived) begin
                    pend_ok_d  = (rx.data == xor_q);
                    pend_bad_d = (rx.data != xor_q);
                    tmo_d      = '0;
                    state_d    = HUNT;
                end else if (tmo_expired) begin
                    timeout_err_d = 1'b1;
                    tmo_d         = '0;
                    state_d       = HUNT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase

        busy_d      = (state_d != HUNT);
        err_count_d = err_count_q;
        if ((cksum_err_d || timeout_err_d) && err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q       <= HUNT;
            buf_q         <= '0;
            cnt_q         <= '0;
            xor_q         <= '0;
            tmo_q         <= '0;
            pend_ok_q     <= 1'b0;
            pend_bad_q    <= 1'b0;
            payload_q     <= '0;
            frame_valid_q <= 1'b0;
            cksum_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            cnt_q         <= cnt_d;
            xor_q         <= xor_d;
            tmo_q         <= tmo_d;
            pend_ok_q     <= pend_ok_d;
            pend_bad_q    <= pend_bad_d;
            payload_q     <= payload_d;
            frame_valid_q <= frame_valid_d;
            cksum_err_q   <= cksum_err_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
            err_count_q   <= err_count_d;
        end
    end

    assign payload     = payload_q;
    assign frame_valid = frame_valid_q;
    assign cksum_err   = cksum_err_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;
    assign err_count   = err_count_q;
endmodule
